// File: rtl/memif_tg_pkg.sv
// Shared types and constants for the SDRAM write/verify traffic generator.
package memif_tg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_DRAIN,
    ST_FIN
  } state_t;

  localparam logic [1:0] PAT_INC  = 2'd0;
  localparam logic [1:0] PAT_LFSR = 2'd1;
  localparam logic [1:0] PAT_WALK = 2'd2;
  localparam logic [1:0] PAT_AXOR = 2'd3;

  // Galois right-shift form of taps 16,14,13,11
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam logic [15:0] AXOR_CONST = 16'h5A5A;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/memif_pattern_src.sv
// Pattern source: word and index for the current position of a pass.
// Restart latches the pattern select and rewinds to word 0.
module memif_pattern_src
  import memif_tg_pkg::*;
#(
  parameter int          ADDR_W     = 24,
  parameter int          DATA_W     = 16,
  parameter int          NUM_WORDS  = 1024,
  parameter int          START_ADDR = 0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          IDX_W      = $clog2(NUM_WORDS + 1)
) (
  input  logic              ref_clk,
  input  logic              reset_n,
  input  logic              restart,
  input  logic              advance,
  input  logic [1:0]        pattern_sel,
  output logic [DATA_W-1:0] word,
  output logic [IDX_W-1:0]  index
);

  logic [1:0]        sel;
  logic [15:0]       lfsr;
  logic [DATA_W-1:0] walk;
  logic [DATA_W-1:0] lfsr_rep;
  logic [DATA_W-1:0] axor_rep;
  logic [DATA_W-1:0] addr_lo;

  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      sel   <= PAT_INC;
      index <= '0;
      lfsr  <= LFSR_SEED;
      walk  <= DATA_W'(1);
    end else if (restart) begin
      sel   <= pattern_sel;
      index <= '0;
      lfsr  <= LFSR_SEED;
      walk  <= DATA_W'(1);
    end else if (advance) begin
      index <= index + 1'b1;
      lfsr  <= lfsr_next(lfsr);
      walk  <= {walk[DATA_W-2:0], walk[DATA_W-1]};
    end
  end

  // Low bits of START_ADDR+index equal the sum of the low bits
  assign addr_lo = DATA_W'(START_ADDR) + DATA_W'(index);

  always_comb begin
    lfsr_rep = '0;
    axor_rep = '0;
    for (int j = 0; j < DATA_W; j++) begin
      lfsr_rep[j] = lfsr[j % 16];
      axor_rep[j] = AXOR_CONST[j % 16];
    end
    unique case (sel)
      PAT_INC:  word = DATA_W'(index);
      PAT_LFSR: word = lfsr_rep;
      PAT_WALK: word = walk;
      default:  word = addr_lo ^ axor_rep;
    endcase
  end

endmodule

// File: rtl/memif_traffic_gen.sv
// Write/verify traffic generator on the local Avalon-MM port of the SDRAM
// controller: fills a range with a pattern, reads it back and checks it.
module memif_traffic_gen
  import memif_tg_pkg::*;
#(
  parameter int          ADDR_W          = 24,
  parameter int          DATA_W          = 16,
  parameter int          NUM_WORDS       = 1024,
  parameter int          START_ADDR      = 0,
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                ref_clk,
  input  logic                reset_n,
  input  logic                write_start_triger,
  input  logic                read_start_triger,
  input  logic [1:0]          pattern_sel,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_read,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  output logic                busy,
  output logic                done,
  output logic                pass_ok,
  output logic [15:0]         err_count,
  output logic [ADDR_W-1:0]   first_err_addr
);

  localparam int IDX_W = $clog2(NUM_WORDS + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [OUT_W-1:0] MAX_OUT  = OUT_W'(MAX_OUTSTANDING);

  state_t            state;
  logic [OUT_W-1:0]  outstanding;
  logic              wr_q, wr_d, rd_q, rd_d;
  logic              wr_edge, rd_edge, start_wr, start_rd;
  logic              wr_acc, rd_acc, rsp, mismatch;
  logic [IDX_W-1:0]  iss_idx, chk_idx;
  logic [DATA_W-1:0] iss_word, chk_word;
  logic [ADDR_W-1:0] iss_addr, chk_addr;

  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= 1'b0;
      wr_d <= 1'b0;
      rd_q <= 1'b0;
      rd_d <= 1'b0;
    end else begin
      wr_q <= write_start_triger;
      wr_d <= wr_q;
      rd_q <= read_start_triger;
      rd_d <= rd_q;
    end
  end

  assign wr_edge  = wr_q & ~wr_d;
  assign rd_edge  = rd_q & ~rd_d;
  assign start_wr = (state == ST_IDLE) && wr_edge;
  assign start_rd = (state == ST_IDLE) && rd_edge && !wr_edge;

  assign iss_addr = ADDR_W'(START_ADDR) + ADDR_W'(iss_idx);
  assign chk_addr = ADDR_W'(START_ADDR) + ADDR_W'(chk_idx);

  assign avm_write      = (state == ST_WR);
  assign avm_read       = (state == ST_RD) && (outstanding < MAX_OUT);
  assign avm_address    = (avm_write || avm_read) ? iss_addr : '0;
  assign avm_writedata  = avm_write ? iss_word : '0;
  assign avm_byteenable = '1;
  assign busy           = (state != ST_IDLE);

  assign wr_acc   = avm_write && !avm_waitrequest;
  assign rd_acc   = avm_read && !avm_waitrequest;
  // Responses count only while a read pass owns them; stale ones after an abort are dropped
  assign rsp      = avm_readdatavalid && (state == ST_RD || state == ST_DRAIN) && (outstanding != '0);
  assign mismatch = rsp && (avm_readdata != chk_word);

  memif_pattern_src #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS),
    .START_ADDR(START_ADDR), .LFSR_SEED(LFSR_SEED), .IDX_W(IDX_W)
  ) u_iss (
    .ref_clk(ref_clk), .reset_n(reset_n), .restart(start_wr || start_rd),
    .advance(wr_acc || rd_acc), .pattern_sel(pattern_sel),
    .word(iss_word), .index(iss_idx)
  );

  memif_pattern_src #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS),
    .START_ADDR(START_ADDR), .LFSR_SEED(LFSR_SEED), .IDX_W(IDX_W)
  ) u_chk (
    .ref_clk(ref_clk), .reset_n(reset_n), .restart(start_wr || start_rd),
    .advance(rsp), .pattern_sel(pattern_sel),
    .word(chk_word), .index(chk_idx)
  );

  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      outstanding    <= '0;
      done           <= 1'b0;
      pass_ok        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      done <= 1'b0;
      if (rd_acc && !rsp)      outstanding <= outstanding + 1'b1;
      else if (!rd_acc && rsp) outstanding <= outstanding - 1'b1;
      if (mismatch) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (err_count == 16'd0)    first_err_addr <= chk_addr;
      end
      unique case (state)
        ST_IDLE: begin
          if (start_wr) begin
            state <= ST_WR;
          end else if (start_rd) begin
            state          <= ST_RD;
            err_count      <= '0;
            first_err_addr <= '0;
            pass_ok        <= 1'b0;
          end
        end
        ST_WR: begin
          if (wr_acc && iss_idx == LAST_IDX) begin
            state <= ST_FIN;
            done  <= 1'b1;
          end
        end
        ST_RD: begin
          if (rd_acc && iss_idx == LAST_IDX) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Nothing in flight, so err_count is final here
          if (outstanding == '0) begin
            state   <= ST_FIN;
            done    <= 1'b1;
            pass_ok <= (err_count == 16'd0);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memif_traffic_gen.sv
// Bench for memif_traffic_gen: Avalon slave memory with configurable latency,
// stalls and corruption, plus a pattern model computed from the word rules.
module tb_memif_traffic_gen;

  localparam int NW   = 16;
  localparam int MAXO = 4;

  logic        ref_clk = 1'b0;
  logic        reset_n;
  logic        write_start_triger, read_start_triger;
  logic [1:0]  pattern_sel;
  logic [23:0] avm_address;
  logic        avm_write, avm_read;
  logic [15:0] avm_writedata;
  logic [1:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [15:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        busy, done, pass_ok;
  logic [15:0] err_count;
  logic [23:0] first_err_addr;

  memif_traffic_gen #(
    .ADDR_W(24), .DATA_W(16), .NUM_WORDS(NW), .START_ADDR(0),
    .MAX_OUTSTANDING(MAXO), .LFSR_SEED(16'hACE1)
  ) dut (
    .ref_clk(ref_clk), .reset_n(reset_n),
    .write_start_triger(write_start_triger), .read_start_triger(read_start_triger),
    .pattern_sel(pattern_sel),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy(busy), .done(done), .pass_ok(pass_ok),
    .err_count(err_count), .first_err_addr(first_err_addr)
  );

  always #5 ref_clk = ~ref_clk;

  typedef struct {
    logic [15:0] data;
    int          due;
  } rsp_t;

  typedef struct {
    logic [1:0]  sel;
    int          lat;
    int          wpct;
    logic [15:0] c5;
    logic [15:0] c9;
    int          exp_err;
    int          exp_first;
    bit          exp_ok;
    logic [15:0] w0;
    logic [15:0] w7;
  } vec_t;

  int          nvec = 0, nerr = 0;
  int          cyc = 0, wait_pct = 0, lat = 1;
  int          wr_k = 0, rd_k = 0, inflight = 0, done_cnt = 0, rsp_cnt = 0, reads_total = 0;
  logic [1:0]  cur_sel = 2'd0;
  logic [15:0] mem   [0:63];
  logic [15:0] cmask [0:63];
  rsp_t        rsp_q [$];
  bit          p_stall = 1'b0, p_w = 1'b0, p_r = 1'b0;
  logic [23:0] p_addr = '0;
  logic [15:0] p_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected word i of a pass, straight from the pattern definitions
  function automatic logic [15:0] exp_word(input logic [1:0] sel, input int i);
    logic [15:0] s;
    s = 16'hACE1;
    case (sel)
      2'd0: return 16'(i);
      2'd1: begin
        for (int k = 0; k < i; k++) s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
        return s;
      end
      2'd2: return 16'd1 << (i % 16);
      default: return 16'(i) ^ 16'h5A5A;
    endcase
  endfunction

  // Avalon slave: drives inputs for the next edge and scores the requests the DUT presents
  initial begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    for (int a = 0; a < 64; a++) begin
      mem[a]   = '0;
      cmask[a] = '0;
    end
    forever begin
      @(negedge ref_clk);
      cyc++;
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = rsp_q[0].data;
        void'(rsp_q.pop_front());
        inflight--;
        rsp_cnt++;
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata      = 16'($urandom);
      end
      avm_waitrequest = (int'($urandom_range(99)) < wait_pct);
      if (done) done_cnt++;
      if (p_stall) begin
        chk("stall_req", {30'd0, avm_write, avm_read}, {30'd0, p_w, p_r});
        chk("stall_addr", {8'd0, avm_address}, {8'd0, p_addr});
        if (p_w) chk("stall_data", {16'd0, avm_writedata}, {16'd0, p_data});
      end
      if (avm_write && !avm_waitrequest) begin
        chk("wr_addr", {8'd0, avm_address}, 32'(wr_k));
        chk("wr_data", {16'd0, avm_writedata}, {16'd0, exp_word(cur_sel, wr_k)});
        chk("wr_be", {30'd0, avm_byteenable}, 32'd3);
        mem[avm_address[5:0]] = avm_writedata;
        wr_k++;
      end
      if (avm_read && !avm_waitrequest) begin
        chk("rd_addr", {8'd0, avm_address}, 32'(rd_k));
        rsp_q.push_back('{data: mem[avm_address[5:0]] ^ cmask[avm_address[5:0]], due: cyc + lat});
        inflight++;
        reads_total++;
        rd_k++;
        if (inflight > MAXO) chk("inflight_max", 32'(inflight), MAXO);
      end
      p_stall = (avm_write || avm_read) && avm_waitrequest;
      p_w     = avm_write;
      p_r     = avm_read;
      p_addr  = avm_address;
      p_data  = avm_writedata;
    end
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, "_req"}, {30'd0, avm_write, avm_read}, 0);
    chk({nm, "_addr"}, {8'd0, avm_address}, 0);
    chk({nm, "_wdata"}, {16'd0, avm_writedata}, 0);
    chk({nm, "_flags"}, {29'd0, busy, done, pass_ok}, 0);
    chk({nm, "_err"}, {16'd0, err_count}, 0);
    chk({nm, "_first"}, {8'd0, first_err_addr}, 0);
  endtask

  task automatic do_pass(input bit rd, input logic [1:0] sel);
    cur_sel  = sel;
    wr_k     = 0;
    rd_k     = 0;
    done_cnt = 0;
    pattern_sel = sel;
    if (rd) read_start_triger = 1'b1;
    else    write_start_triger = 1'b1;
    @(negedge ref_clk);
    chk("lat_1cyc", {29'd0, busy, avm_write, avm_read}, 0);
    @(negedge ref_clk);
    chk("lat_2cyc", {29'd0, busy, avm_write, avm_read}, rd ? 32'd5 : 32'd6);
    pattern_sel        = ~sel;
    write_start_triger = 1'b0;
    read_start_triger  = 1'b0;
    for (int c = 0; c < 1500 && done_cnt == 0; c++) @(negedge ref_clk);
    repeat (2) @(negedge ref_clk);
    chk("done_once", 32'(done_cnt), 1);
    chk("busy_end", {31'd0, busy}, 0);
    chk("word_count", 32'(rd ? rd_k : wr_k), NW);
  endtask

  vec_t vt [5];

  initial begin
    vt[0] = '{sel: 2'd0, lat: 1, wpct: 0,  c5: 16'h0,    c9: 16'h0,    exp_err: 0, exp_first: 0, exp_ok: 1'b1, w0: 16'h0000, w7: 16'h0007};
    vt[1] = '{sel: 2'd1, lat: 3, wpct: 0,  c5: 16'h0,    c9: 16'h0,    exp_err: 0, exp_first: 0, exp_ok: 1'b1, w0: 16'hACE1, w7: 16'hED89};
    vt[2] = '{sel: 2'd0, lat: 2, wpct: 0,  c5: 16'h0001, c9: 16'h0100, exp_err: 2, exp_first: 5, exp_ok: 1'b0, w0: 16'h0000, w7: 16'h0007};
    vt[3] = '{sel: 2'd2, lat: 2, wpct: 50, c5: 16'h0,    c9: 16'h0,    exp_err: 0, exp_first: 0, exp_ok: 1'b1, w0: 16'h0001, w7: 16'h0080};
    vt[4] = '{sel: 2'd3, lat: 4, wpct: 20, c5: 16'h0,    c9: 16'h8000, exp_err: 1, exp_first: 9, exp_ok: 1'b0, w0: 16'h5A5A, w7: 16'h5A5D};

    reset_n            = 1'b0;
    write_start_triger = 1'b0;
    read_start_triger  = 1'b0;
    pattern_sel        = 2'd0;
    repeat (3) @(negedge ref_clk);
    chk_all_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge ref_clk);

    for (int v = 0; v < 5; v++) begin
      lat      = vt[v].lat;
      wait_pct = vt[v].wpct;
      cmask[5] = vt[v].c5;
      cmask[9] = vt[v].c9;
      do_pass(1'b0, vt[v].sel);
      chk($sformatf("v%0d_word0", v), {16'd0, mem[0]}, {16'd0, vt[v].w0});
      chk($sformatf("v%0d_word7", v), {16'd0, mem[7]}, {16'd0, vt[v].w7});
      do_pass(1'b1, vt[v].sel);
      chk($sformatf("v%0d_err_count", v), {16'd0, err_count}, 32'(vt[v].exp_err));
      chk($sformatf("v%0d_first_err", v), {8'd0, first_err_addr}, 32'(vt[v].exp_first));
      chk($sformatf("v%0d_pass_ok", v), {31'd0, pass_ok}, {31'd0, vt[v].exp_ok});
      cmask[5] = '0;
      cmask[9] = '0;
    end

    // Randomized passes against the model: random pattern, latency, stalls, corruption
    for (int it = 0; it < 8; it++) begin
      logic [1:0] sel;
      int n_bad, first;
      sel      = 2'($urandom_range(3));
      lat      = $urandom_range(1, 5);
      wait_pct = $urandom_range(0, 60);
      n_bad    = 0;
      first    = 0;
      for (int a = 0; a < NW; a++) begin
        cmask[a] = '0;
        if ($urandom_range(7) == 0) begin
          cmask[a] = 16'($urandom_range(1, 65535));
          if (n_bad == 0) first = a;
          n_bad++;
        end
      end
      do_pass(1'b0, sel);
      do_pass(1'b1, sel);
      chk("rnd_err_count", {16'd0, err_count}, 32'(n_bad));
      chk("rnd_first_err", {8'd0, first_err_addr}, 32'(first));
      chk("rnd_pass_ok", {31'd0, pass_ok}, (n_bad == 0) ? 32'd1 : 32'd0);
    end
    for (int a = 0; a < 64; a++) cmask[a] = '0;

    // Simultaneous edges: write wins; a read edge while busy is ignored
    lat = 1; wait_pct = 0;
    wr_k = 0; rd_k = 0; done_cnt = 0; reads_total = 0;
    cur_sel = 2'd0; pattern_sel = 2'd0;
    write_start_triger = 1'b1;
    read_start_triger  = 1'b1;
    repeat (2) @(negedge ref_clk);
    read_start_triger = 1'b0;
    repeat (2) @(negedge ref_clk);
    read_start_triger = 1'b1;
    repeat (2) @(negedge ref_clk);
    read_start_triger  = 1'b0;
    write_start_triger = 1'b0;
    for (int c = 0; c < 1500 && done_cnt == 0; c++) @(negedge ref_clk);
    repeat (20) @(negedge ref_clk);
    chk("both_done_once", 32'(done_cnt), 1);
    chk("both_no_reads", 32'(reads_total), 0);
    chk("both_writes", 32'(wr_k), NW);
    chk("both_idle", {31'd0, busy}, 0);

    // Reset mid-read after 3 responses, then a clean read pass
    lat = 3; cmask[1] = 16'h0001;
    rd_k = 0; rsp_cnt = 0; cur_sel = 2'd0; pattern_sel = 2'd0;
    read_start_triger = 1'b1;
    for (int c = 0; c < 200 && rsp_cnt < 3; c++) @(negedge ref_clk);
    @(negedge ref_clk);
    chk("pre_rst_busy", {31'd0, busy}, 1);
    chk("pre_rst_err", {16'd0, err_count}, 1);
    chk("pre_rst_first", {8'd0, first_err_addr}, 1);
    reset_n = 1'b0;
    #1;
    chk_all_zero("abort");
    read_start_triger = 1'b0;
    repeat (3) @(negedge ref_clk);
    reset_n = 1'b1;
    for (int c = 0; c < 200 && rsp_q.size() > 0; c++) @(negedge ref_clk);
    chk("abort_drained", 32'(rsp_q.size()), 0);
    chk("abort_stale_ignored", {16'd0, err_count}, 0);
    cmask[1] = '0;
    repeat (2) @(negedge ref_clk);
    do_pass(1'b1, 2'd0);
    chk("post_rst_err", {16'd0, err_count}, 0);
    chk("post_rst_ok", {31'd0, pass_ok}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
